// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: address map, operation
// encoding, mstatus field positions and the misa constant.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  // MXL in the top two bits of the native width; I (bit 8) and M (bit 12).
  function automatic logic [63:0] misa_value(input int xlen);
    if (xlen == 64) return 64'h8000_0000_0000_1100;
    else            return 64'h0000_0000_4000_1100;
  endfunction

endpackage

// File: rtl/csr_if.sv
// CSR access bus between the execute stage (master) and the CSR file (slave).
interface csr_if #(parameter int XLEN = 32);
  logic            csr_valid;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  modport master (output csr_valid, csr_op, csr_addr, csr_wdata,
                  input  csr_rdata, csr_illegal);
  modport slave  (input  csr_valid, csr_op, csr_addr, csr_wdata,
                  output csr_rdata, csr_illegal);
endinterface

// File: rtl/csr_counter64.sv
// 64-bit wrapping event counter with independently writable 32-bit halves.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [63:0] wdata,
  output logic [63:0] q
);

  logic [63:0] q_q, q_d;

  // A write to either half suppresses the increment for that cycle.
  always_comb begin
    q_d = q_q;
    if (wr_lo || wr_hi) begin
      if (wr_lo) q_d[31:0]  = wdata[31:0];
      if (wr_hi) q_d[63:32] = wdata[63:32];
    end else if (inc) begin
      q_d = q_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: atomic CSR read/modify/write, trap entry and MRET
// stacking of MIE/MPIE, and the mcycle/minstret counters.
module csr_file
  import csr_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
  parameter bit              HAS_COUNTERS = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  csr_if.slave            bus,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic            mret_valid,
  input  logic            instret_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mie_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic [63:0]     mcycle_q, minstret_q, cnt_wdata;

  csr_op_e         op;
  logic            mapped, would_write, illegal, do_write;
  logic [XLEN-1:0] old_val, wval, mstatus_rd;

  assign op = csr_op_e'(bus.csr_op);

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE]                   = mie_q;
    mstatus_rd[MSTATUS_MPIE]                  = mpie_q;
    mstatus_rd[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO] = 2'b11;

    mapped  = 1'b1;
    old_val = '0;
    case (bus.csr_addr)
      ADDR_MSTATUS:  old_val = mstatus_rd;
      ADDR_MISA:     old_val = XLEN'(misa_value(XLEN));
      ADDR_MTVEC:    old_val = mtvec_q;
      ADDR_MSCRATCH: old_val = mscratch_q;
      ADDR_MEPC:     old_val = mepc_q;
      ADDR_MCAUSE:   old_val = mcause_q;
      ADDR_MCYCLE:   old_val = XLEN'(mcycle_q);
      ADDR_MINSTRET: old_val = XLEN'(minstret_q);
      ADDR_MCYCLEH:   if (XLEN == 32) old_val = XLEN'(mcycle_q[63:32]);   else mapped = 1'b0;
      ADDR_MINSTRETH: if (XLEN == 32) old_val = XLEN'(minstret_q[63:32]); else mapped = 1'b0;
      ADDR_MHARTID:  old_val = '0;
      default:       mapped = 1'b0;
    endcase

    // Set/clear with a zero operand is a pure read, which keeps it legal on read-only CSRs.
    would_write = bus.csr_valid &&
                  (op == CSR_RW || (op != CSR_NONE && bus.csr_wdata != '0));
    illegal  = bus.csr_valid &&
               (!mapped || (bus.csr_addr[11:10] == 2'b11 && would_write));
    do_write = would_write && !illegal;

    case (op)
      CSR_RW:  wval = bus.csr_wdata;
      CSR_RS:  wval = old_val | bus.csr_wdata;
      CSR_RC:  wval = old_val & ~bus.csr_wdata;
      default: wval = old_val;
    endcase
  end

  assign bus.csr_rdata   = illegal ? '0 : old_val;
  assign bus.csr_illegal = illegal;

  // Trap beats MRET beats a CSR write for mstatus/mepc/mcause; other CSRs are untouched by traps.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;

    if (trap_valid) begin
      mepc_d   = trap_pc & ALIGN_MASK;
      mcause_d = trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_valid) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (do_write) begin
      case (bus.csr_addr)
        ADDR_MSTATUS: begin
          mie_d  = wval[MSTATUS_MIE];
          mpie_d = wval[MSTATUS_MPIE];
        end
        ADDR_MEPC:   mepc_d   = wval & ALIGN_MASK;
        ADDR_MCAUSE: mcause_d = wval;
        default: ;
      endcase
    end

    if (do_write) begin
      case (bus.csr_addr)
        ADDR_MTVEC:    mtvec_d    = wval & ALIGN_MASK;
        ADDR_MSCRATCH: mscratch_d = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET & ALIGN_MASK;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  // On RV32 the same word feeds both halves; the write strobes pick which one lands.
  if (XLEN == 32) begin : g_wd32
    assign cnt_wdata = {wval, wval};
  end else begin : g_wd64
    assign cnt_wdata = 64'(wval);
  end

  if (HAS_COUNTERS) begin : g_cnt
    csr_counter64 u_mcycle (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc   (1'b1),
      .wr_lo (do_write && bus.csr_addr == ADDR_MCYCLE),
      .wr_hi (do_write && (bus.csr_addr == ADDR_MCYCLEH ||
                           (XLEN != 32 && bus.csr_addr == ADDR_MCYCLE))),
      .wdata (cnt_wdata),
      .q     (mcycle_q)
    );
    csr_counter64 u_minstret (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc   (instret_i),
      .wr_lo (do_write && bus.csr_addr == ADDR_MINSTRET),
      .wr_hi (do_write && (bus.csr_addr == ADDR_MINSTRETH ||
                           (XLEN != 32 && bus.csr_addr == ADDR_MINSTRET))),
      .wdata (cnt_wdata),
      .q     (minstret_q)
    );
  end else begin : g_nocnt
    assign mcycle_q   = '0;
    assign minstret_q = '0;
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;
  assign mie_o   = mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file (RV32): vector table for single-cycle CSR
// accesses plus hand sequences for traps, MRET, counters and async reset.
module tb_csr_file;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        trap_valid, mret_valid, instret_i;
  logic [31:0] trap_pc, trap_cause;
  logic [31:0] mtvec_o, mepc_o;
  logic        mie_o;

  int tests = 0;
  int fails = 0;

  csr_if #(.XLEN(32)) bus ();

  csr_file #(
    .XLEN         (32),
    .MTVEC_RESET  (32'h8000_0103),
    .HAS_COUNTERS (1'b1)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .bus        (bus),
    .trap_valid (trap_valid),
    .trap_pc    (trap_pc),
    .trap_cause (trap_cause),
    .mret_valid (mret_valid),
    .instret_i  (instret_i),
    .mtvec_o    (mtvec_o),
    .mepc_o     (mepc_o),
    .mie_o      (mie_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    bus.csr_valid = 1'b1;
    bus.csr_op    = op;
    bus.csr_addr  = addr;
    bus.csr_wdata = wd;
  endtask

  task automatic idle();
    bus.csr_valid = 1'b0;
    bus.csr_op    = 2'b00;
    bus.csr_wdata = '0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
    drive(2'b00, addr, 32'h0);
    #1;
    chk(name, bus.csr_rdata, exp);
  endtask

  initial begin
    vecs[0]  = '{2'b01, 12'h340, 32'hA5A5_0000, 32'h0000_0000, 1'b0};
    vecs[1]  = '{2'b10, 12'h340, 32'h0000_00FF, 32'hA5A5_0000, 1'b0};
    vecs[2]  = '{2'b11, 12'h340, 32'hA500_0000, 32'hA5A5_00FF, 1'b0};
    vecs[3]  = '{2'b00, 12'h340, 32'h0000_0000, 32'h00A5_00FF, 1'b0};
    vecs[4]  = '{2'b00, 12'h300, 32'h0000_0000, 32'h0000_1800, 1'b0};
    vecs[5]  = '{2'b10, 12'h300, 32'h0000_0008, 32'h0000_1800, 1'b0};
    vecs[6]  = '{2'b00, 12'h300, 32'h0000_0000, 32'h0000_1808, 1'b0};
    vecs[7]  = '{2'b00, 12'h301, 32'h0000_0000, 32'h4000_1100, 1'b0};
    vecs[8]  = '{2'b01, 12'h301, 32'h0000_0000, 32'h4000_1100, 1'b0};
    vecs[9]  = '{2'b00, 12'h301, 32'h0000_0000, 32'h4000_1100, 1'b0};
    vecs[10] = '{2'b01, 12'hF14, 32'h0000_0005, 32'h0000_0000, 1'b1};
    vecs[11] = '{2'b10, 12'hF14, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[12] = '{2'b00, 12'h7C0, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[13] = '{2'b01, 12'h305, 32'h0000_1237, 32'h8000_0100, 1'b0};
    vecs[14] = '{2'b00, 12'h305, 32'h0000_0000, 32'h0000_1234, 1'b0};
    vecs[15] = '{2'b01, 12'h341, 32'h0000_2003, 32'h0000_0000, 1'b0};
    vecs[16] = '{2'b00, 12'h341, 32'h0000_0000, 32'h0000_2000, 1'b0};
    vecs[17] = '{2'b01, 12'h342, 32'h8000_000B, 32'h0000_0000, 1'b0};
    vecs[18] = '{2'b00, 12'h342, 32'h0000_0000, 32'h8000_000B, 1'b0};
    vecs[19] = '{2'b11, 12'h300, 32'h0000_0000, 32'h0000_1808, 1'b0};

    rst_i = 1'b1;
    trap_valid = 1'b0; mret_valid = 1'b0; instret_i = 1'b0;
    trap_pc = '0; trap_cause = '0;
    bus.csr_addr = '0;
    idle();

    // Reset state
    @(negedge clk_i);
    chk("reset_mtvec", mtvec_o, 32'h8000_0100);
    chk("reset_mepc", mepc_o, 32'h0);
    chk("reset_mie", {31'b0, mie_o}, 32'h0);
    rd_chk("reset_mstatus", 12'h300, 32'h0000_1800);
    rst_i = 1'b0;
    idle();
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].addr, vecs[i].wdata);
      #1;
      chk($sformatf("vec%0d_rdata", i), bus.csr_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_illegal", i), {31'b0, bus.csr_illegal}, {31'b0, vecs[i].exp_ill});
      tick();
    end
    idle();
    chk("out_mtvec", mtvec_o, 32'h0000_1234);
    chk("out_mepc", mepc_o, 32'h0000_2000);
    chk("out_mie", {31'b0, mie_o}, 32'h1);

    // Trap entry then MRET
    trap_valid = 1'b1; trap_pc = 32'h8000_1006; trap_cause = 32'hB;
    tick();
    trap_valid = 1'b0;
    chk("trap_mepc", mepc_o, 32'h8000_1004);
    chk("trap_mie", {31'b0, mie_o}, 32'h0);
    rd_chk("trap_mcause", 12'h342, 32'h0000_000B);
    rd_chk("trap_mstatus", 12'h300, 32'h0000_1880);
    idle();
    mret_valid = 1'b1;
    tick();
    mret_valid = 1'b0;
    rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);
    chk("mret_mie", {31'b0, mie_o}, 32'h1);

    // Trap wins over a CSR write to mepc
    drive(2'b01, 12'h341, 32'h0000_1234);
    trap_valid = 1'b1; trap_pc = 32'h0000_4447; trap_cause = 32'h2;
    tick();
    trap_valid = 1'b0;
    chk("simul_mepc", mepc_o, 32'h0000_4444);
    rd_chk("simul_mcause", 12'h342, 32'h0000_0002);

    // Trap does not block a write to mscratch
    drive(2'b01, 12'h340, 32'h0000_0055);
    trap_valid = 1'b1; trap_pc = 32'h0000_0009; trap_cause = 32'h3;
    tick();
    trap_valid = 1'b0;
    chk("simul2_mepc", mepc_o, 32'h0000_0008);
    rd_chk("simul2_mscratch", 12'h340, 32'h0000_0055);
    rd_chk("simul2_mstatus", 12'h300, 32'h0000_1800);

    // MRET wins over a CSR write to mstatus
    drive(2'b01, 12'h300, 32'h0000_0008);
    mret_valid = 1'b1;
    tick();
    mret_valid = 1'b0;
    rd_chk("mret_vs_wr_mstatus", 12'h300, 32'h0000_1880);

    // Illegal writes leave state alone
    drive(2'b01, 12'h7C0, 32'hDEAD_BEEF);
    #1;
    chk("ill_unmapped_wr", {31'b0, bus.csr_illegal}, 32'h1);
    tick();
    drive(2'b01, 12'hF14, 32'hFFFF_FFFF);
    tick();
    rd_chk("ill_mscratch_kept", 12'h340, 32'h0000_0055);
    rd_chk("ill_mhartid_zero", 12'hF14, 32'h0);

    // mcycle carry into mcycleh
    drive(2'b01, 12'hB00, 32'hFFFF_FFFE);
    tick();
    drive(2'b01, 12'hB80, 32'h0000_0000);
    tick();
    rd_chk("mcycle_hold_on_hi_wr", 12'hB00, 32'hFFFF_FFFE);
    tick();
    rd_chk("mcycle_ff", 12'hB00, 32'hFFFF_FFFF);
    rd_chk("mcycleh_0", 12'hB80, 32'h0);
    tick();
    rd_chk("mcycle_wrap", 12'hB00, 32'h0);
    rd_chk("mcycleh_carry", 12'hB80, 32'h1);

    // minstret counts only retire pulses
    drive(2'b01, 12'hB02, 32'h0);
    tick();
    drive(2'b01, 12'hB82, 32'h0);
    tick();
    idle();
    for (int i = 0; i < 14; i++) begin
      instret_i = (i % 2 == 0);
      tick();
    end
    instret_i = 1'b0;
    rd_chk("minstret_7", 12'hB02, 32'h7);
    rd_chk("minstreth_0", 12'hB82, 32'h0);

    // Asynchronous reset mid-cycle
    drive(2'b10, 12'h300, 32'h0000_0008);
    tick();
    idle();
    chk("pre_reset_mie", {31'b0, mie_o}, 32'h1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_mtvec", mtvec_o, 32'h8000_0100);
    chk("async_mepc", mepc_o, 32'h0);
    chk("async_mie", {31'b0, mie_o}, 32'h0);
    rd_chk("async_mstatus", 12'h300, 32'h0000_1800);
    rd_chk("async_mscratch", 12'h340, 32'h0);
    tick();
    rst_i = 1'b0;
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR file for the single-issue RV32/RV64 core. It replaces the two-register trap CSR block.
- Implements the atomic CSRRW/CSRRS/CSRRC operations on a full M-mode register set.
- Handles trap entry and MRET stacking of mstatus.MIE/MPIE.
- Owns the free-running mcycle/minstret counters.
- Sits beside the execute stage. Reads are combinational. Writes commit on the next clk_i edge.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- MTVEC_RESET, 0, reset value of mtvec (bits [1:0] forced 0).
- HAS_COUNTERS, 1, 1 = mcycle/minstret implemented; 0 = those addresses read 0 and writes are ignored (still legal).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- csr_valid  in  1  CSR instruction present this cycle.
- csr_op  in  2  01=RW, 10=RS, 11=RC; 00 = read only, no write.
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  rs1/uimm operand.
- csr_rdata  out  XLEN  old value of addressed CSR (combinational).
- csr_illegal  out  1  unknown address, or write attempt to a read-only CSR (combinational).
- trap_valid  in  1  take trap this cycle.
- trap_pc  in  XLEN  faulting PC.
- trap_cause  in  XLEN  mcause value.
- mret_valid  in  1  MRET retiring this cycle.
- instret_i  in  1  one instruction retired this cycle.
- mtvec_o  out  XLEN  current mtvec.
- mepc_o  out  XLEN  current mepc.
- mie_o  out  1  current mstatus.MIE.

Behaviour:
- Address map:
  - 0x300 mstatus: MIE bit3, MPIE bit7, MPP[12:11] read 2'b11; all other bits read 0.
  - 0x301 misa: read-only constant. MXL = 1 for XLEN 32, 2 for XLEN 64; I and M bits set.
  - 0x305 mtvec: bits[1:0] read 0 (direct mode only).
  - 0x340 mscratch: full XLEN.
  - 0x341 mepc: bits[1:0] read 0.
  - 0x342 mcause: full XLEN.
  - 0xB00 mcycle and 0xB02 minstret.
  - 0xB80 mcycleh and 0xB82 minstreth: exist only when XLEN==32; otherwise illegal.
  - 0xF14 mhartid: reads 0.
- Write value:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - A write occurs when csr_valid && !csr_illegal && (op==RW || (op!=00 && wdata!=0)).
- Illegal conditions (csr_illegal asserted):
  - address unmapped; or
  - addr[11:10]==2'b11 (read-only space) and a write would occur.
  - When illegal, no CSR state changes. csr_rdata then reads 0.
- Write latency: a write is visible on csr_rdata and outputs the cycle after the edge. A read in the same cycle returns the old value.
- Counters:
  - mcycle is 64 bits and increments every cycle out of reset.
  - minstret is 64 bits and increments when instret_i=1.
  - Both wrap from 2^64-1 to 0.
  - A CSR write to any half replaces that half. That counter does not increment in the write cycle. The other half keeps its pre-write value.
- Trap entry (trap_valid=1), at the edge:
  - mepc <= trap_pc & ~3.
  - mcause <= trap_cause.
  - MPIE <= MIE.
  - MIE <= 0.
- MRET (mret_valid=1), at the edge:
  - MIE <= MPIE.
  - MPIE <= 1.
- Simultaneous events, priority trap > mret > CSR write:
  - A lower-priority event's writes to mstatus/mepc/mcause are dropped.
  - A CSR write to a CSR the trap does not touch (e.g. mscratch) still commits.
  - Counters always update independently of trap/mret.
- Reset: all outputs and registers are 0, except mtvec = MTVEC_RESET & ~3. Reset during any operation aborts it; no partial state is retained.

Decomposition:
- Package csr_pkg holds:
  - CSR address localparams;
  - csr_op_e enum (NONE/RW/RS/RC);
  - mstatus bit-index constants;
  - misa_value(XLEN) function.
- Sub-module csr_counter64 (clk_i, rst_i, inc, wr_lo, wr_hi, wdata, q[63:0]) is instantiated twice (mcycle, minstret).

Test Plan:
- Reset: MTVEC_RESET=0x80000103, assert rst_i mid-cycle -> mtvec_o=0x80000100 immediately; mepc_o=0, mie_o=0, csr_rdata of 0x300 = 0x1800.
- RW/RS/RC on mscratch:
  - RW 0xA5A5_0000, then RS 0x0000_00FF -> rdata 0xA5A5_0000.
  - Next RC 0xA500_0000 -> rdata 0xA5A5_00FF.
  - Final read 0x00A5_00FF.
- Trap/MRET:
  - Set MIE via RS 0x8; trap_pc=0x8000_1006, cause=0xB -> mepc_o=0x8000_1004, mcause=0xB, mstatus reads 0x1880.
  - mret -> mstatus 0x1888.
- Simultaneous: trap_valid with CSR RW mepc=0x1234 and RW mscratch=0x55 in same cycle -> mepc = trap_pc & ~3, mscratch=0x55.
- Counters (XLEN 32):
  - write mcycle=0xFFFF_FFFE, mcycleh=0 -> after 2 further cycles mcycleh=1, mcycle=0.
  - minstret counts only instret_i pulses (7 pulses -> 7).
- Illegal: RW to 0xF14 -> csr_illegal=1, no state change; RS 0 to 0xF14 -> csr_illegal=0, rdata=0; read of 0x7C0 -> csr_illegal=1.
